bus_req_retry_ctrl: RTL and testbench

//  Master-side request controller driving a cycle-timeout counter (ready/thresh pair):

---
 rtl/bus_req_retry_ctrl.sv | 104 ++++++++++
 tb/tb_bus_req_retry_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_req_retry_ctrl.sv
// Master-side bus request controller: raises bus_req, waits for slave_ready and retries
// after a fixed backoff when the external timeout counter flags thresh.
module bus_req_retry_ctrl #(
   parameter int unsigned MAX_RETRY = 3,
   parameter int unsigned BACKOFF   = 8,
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1,
   localparam int unsigned BW = (BACKOFF > 1) ? $clog2(BACKOFF) : 1
) (
   input  logic          clk,
   input  logic          rstN,
   input  logic          start,
   input  logic          slave_ready,
   input  logic          thresh,
   output logic          cnt_ready,
   output logic          bus_req,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [RW-1:0] retry_cnt
);

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StBackoff,
      StDone,
      StErr
   } state_e;

   localparam logic [RW-1:0] RetryMax = RW'(MAX_RETRY);
   localparam logic [BW-1:0] BoLast   = BW'(BACKOFF - 1);

   state_e        state;
   logic [BW-1:0] bo_cnt;

   // Outputs are registered together with the state so each one is a pure function of
   // the state just entered; no input reaches an output combinationally.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state     <= StIdle;
         bo_cnt    <= '0;
         retry_cnt <= '0;
         cnt_ready <= 1'b1;
         bus_req   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  state     <= StReq;
                  retry_cnt <= '0;
                  bus_req   <= 1'b1;
                  busy      <= 1'b1;
                  cnt_ready <= 1'b0;
               end
            end
            StReq: begin
               if (slave_ready) begin
                  state     <= StDone;
                  bus_req   <= 1'b0;
                  cnt_ready <= 1'b1;
                  done      <= 1'b1;
               end else if (thresh) begin
                  bus_req   <= 1'b0;
                  cnt_ready <= 1'b1;
                  if (retry_cnt == RetryMax) begin
                     state <= StErr;
                     err   <= 1'b1;
                  end else begin
                     state     <= StBackoff;
                     retry_cnt <= retry_cnt + RW'(1);
                     bo_cnt    <= '0;
                  end
               end
            end
            StBackoff: begin
               // Leave on the last of exactly BACKOFF idle cycles.
               if (bo_cnt == BoLast) begin
                  state     <= StReq;
                  bus_req   <= 1'b1;
                  cnt_ready <= 1'b0;
               end else begin
                  bo_cnt <= bo_cnt + BW'(1);
               end
            end
            StDone, StErr: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
            default: begin
               state     <= StIdle;
               bus_req   <= 1'b0;
               busy      <= 1'b0;
               cnt_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_req_retry_ctrl.sv
// Directed bench for bus_req_retry_ctrl with a model of the external timeout counter
// (THRESH=100), MAX_RETRY=3, BACKOFF=8.
module tb_bus_req_retry_ctrl;

   localparam int unsigned MAX_RETRY = 3;
   localparam int unsigned BACKOFF   = 8;
   localparam int          THRESH    = 100;

   logic       clk;
   logic       rstN;
   logic       start;
   logic       slave_ready;
   logic       force_thresh;
   logic       thresh;
   logic       cnt_ready;
   logic       bus_req;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] retry_cnt;

   int vectors     = 0;
   int miscompares = 0;
   int cnt;
   int m_req  = 0;
   int m_done = 0;
   int m_err  = 0;
   int m_bo   = 0;
   int m_rise = 0;
   logic req_prev = 1'b0;
   int b_req, b_done, b_err, b_bo, b_rise;
   int n;

   bus_req_retry_ctrl #(
      .MAX_RETRY(MAX_RETRY),
      .BACKOFF  (BACKOFF)
   ) dut (
      .clk        (clk),
      .rstN       (rstN),
      .start      (start),
      .slave_ready(slave_ready),
      .thresh     (thresh),
      .cnt_ready  (cnt_ready),
      .bus_req    (bus_req),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .retry_cnt  (retry_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External cycle counter: cleared while cnt_ready is high, counts otherwise.
   always @(posedge clk or negedge rstN) begin
      if (!rstN)          cnt <= 0;
      else if (cnt_ready) cnt <= 0;
      else                cnt <= cnt + 1;
   end
   assign thresh = force_thresh | (cnt == THRESH);

   always @(negedge clk) begin
      if (rstN) begin
         m_req  = m_req + int'(bus_req);
         m_done = m_done + int'(done);
         m_err  = m_err + int'(err);
         if (busy && !bus_req && !done && !err) m_bo = m_bo + 1;
         if (bus_req && !req_prev) m_rise = m_rise + 1;
         req_prev = bus_req;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic snap();
      b_req  = m_req;
      b_done = m_done;
      b_err  = m_err;
      b_bo   = m_bo;
      b_rise = m_rise;
   endtask

   // Ticks until bus_req equals v; returns tick count, or -1 if the bound expires.
   task automatic wait_req(input logic v, input int limit, output int cycles);
      cycles = -1;
      for (int i = 1; i <= limit; i++) begin
         tick();
         if (bus_req === v) begin
            cycles = i;
            return;
         end
      end
   endtask

   initial begin
      rstN         = 1'b0;
      start        = 1'b0;
      slave_ready  = 1'b0;
      force_thresh = 1'b0;
      #12;
      chk("rst_bus_req", bus_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_retry_cnt", retry_cnt, 0);
      chk("rst_cnt_ready", cnt_ready, 1);
      rstN = 1'b1;
      tick();

      // 1: slave answers on the sixth REQ cycle.
      snap();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_bus_req", bus_req, 1);
      chk("t1_busy", busy, 1);
      chk("t1_cnt_ready", cnt_ready, 0);
      repeat (5) tick();
      slave_ready = 1'b1;
      tick();
      slave_ready = 1'b0;
      chk("t1_done", done, 1);
      chk("t1_bus_req_low", bus_req, 0);
      chk("t1_busy_hold", busy, 1);
      chk("t1_cnt_ready_back", cnt_ready, 1);
      tick();
      chk("t1_done_pulse", done, 0);
      chk("t1_busy_low", busy, 0);
      chk("t1_retry_cnt", retry_cnt, 0);
      chk("t1_req_cycles", m_req - b_req, 6);
      chk("t1_done_count", m_done - b_done, 1);

      // 2: slave silent, all attempts time out.
      snap();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = -1;
      for (int i = 1; i <= 1000; i++) begin
         tick();
         if (err === 1'b1) begin
            n = i;
            break;
         end
      end
      chk("t2_err_latency", n, 428);
      chk("t2_retry_cnt", retry_cnt, 3);
      chk("t2_req_cycles", m_req - b_req, 404);
      chk("t2_attempts", m_rise - b_rise, 4);
      chk("t2_backoff_cycles", m_bo - b_bo, 24);
      tick();
      chk("t2_err_pulse", err, 0);
      chk("t2_busy_low", busy, 0);
      chk("t2_err_count", m_err - b_err, 1);
      chk("t2_no_done", m_done - b_done, 0);
      chk("t2_retry_hold", retry_cnt, 3);

      // 3: first attempt times out, second answered on its tenth cycle.
      snap();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_req(1'b0, 200, n);
      chk("t3_window", n, 101);
      chk("t3_retry_mid", retry_cnt, 1);
      wait_req(1'b1, 20, n);
      chk("t3_gap", n, 8);
      repeat (9) tick();
      slave_ready = 1'b1;
      tick();
      slave_ready = 1'b0;
      chk("t3_done", done, 1);
      chk("t3_retry_cnt", retry_cnt, 1);
      tick();
      chk("t3_busy_low", busy, 0);
      chk("t3_done_count", m_done - b_done, 1);
      chk("t3_req_cycles", m_req - b_req, 111);
      chk("t3_backoff_cycles", m_bo - b_bo, 8);

      // 4: slave_ready and thresh together; slave_ready wins.
      snap();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (2) tick();
      slave_ready  = 1'b1;
      force_thresh = 1'b1;
      tick();
      slave_ready  = 1'b0;
      force_thresh = 1'b0;
      chk("t4_done", done, 1);
      chk("t4_bus_req_low", bus_req, 0);
      chk("t4_retry_cnt", retry_cnt, 0);
      tick();
      chk("t4_busy_low", busy, 0);
      chk("t4_no_backoff", m_bo - b_bo, 0);
      chk("t4_no_err", m_err - b_err, 0);

      // 5: inputs outside their sampling states have no effect.
      snap();
      slave_ready  = 1'b1;
      force_thresh = 1'b1;
      repeat (2) tick();
      slave_ready  = 1'b0;
      force_thresh = 1'b0;
      chk("t5_idle_busy", busy, 0);
      chk("t5_idle_bus_req", bus_req, 0);
      start = 1'b1;
      tick();
      repeat (3) tick();
      start = 1'b0;
      chk("t5_req_hold", bus_req, 1);
      wait_req(1'b0, 200, n);
      chk("t5_timeout", n, 98);
      start = 1'b1;
      repeat (3) tick();
      start = 1'b0;
      chk("t5_bo_bus_req", bus_req, 0);
      chk("t5_bo_busy", busy, 1);
      wait_req(1'b1, 20, n);
      chk("t5_bo_rest", n, 5);
      slave_ready = 1'b1;
      tick();
      slave_ready = 1'b0;
      chk("t5_done", done, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t5_start_in_done", busy, 0);
      tick();
      chk("t5_still_idle", bus_req, 0);
      chk("t5_done_count", m_done - b_done, 1);
      chk("t5_retry_cnt", retry_cnt, 1);

      // 6: asynchronous reset during the second backoff.
      snap();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_req(1'b0, 200, n);
      wait_req(1'b1, 20, n);
      wait_req(1'b0, 200, n);
      chk("t6_retry_before", retry_cnt, 2);
      repeat (3) tick();
      #2 rstN = 1'b0;
      #1;
      chk("t6_rst_bus_req", bus_req, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_retry_cnt", retry_cnt, 0);
      chk("t6_rst_cnt_ready", cnt_ready, 1);
      chk("t6_rst_err", err, 0);
      repeat (2) tick();
      rstN = 1'b1;
      tick();
      chk("t6_idle_after", busy, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t6_restart_bus_req", bus_req, 1);
      chk("t6_restart_retry", retry_cnt, 0);
      slave_ready = 1'b1;
      tick();
      slave_ready = 1'b0;
      tick();
      chk("t6_no_err", m_err - b_err, 0);
      chk("t6_done_count", m_done - b_done, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
